// File: rtl/sniffer_pkg.sv
// rtl/sniffer_pkg.sv - shared types and constants for the bus sniffer window controller
package sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH    = 256;
    localparam int DEFAULT_COUNTER_WIDTH = 32;
    localparam int BIT_SHIFT             = $clog2(DEFAULT_DATA_WIDTH);

    // Result snapshot as seen by the register-interface block
    typedef struct packed {
        logic [DEFAULT_COUNTER_WIDTH-1:0]           beat;
        logic [DEFAULT_COUNTER_WIDTH-1:0]           stall;
        logic [DEFAULT_COUNTER_WIDTH+BIT_SHIFT-1:0] bits;
    } result_t;

endpackage

// File: rtl/sniffer_window_timer.sv
// rtl/sniffer_window_timer.sv - loadable window down-counter with last-cycle flag
module sniffer_window_timer #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     en,
    input  logic [COUNTER_WIDTH-1:0] win_len,
    output logic                     last_cycle
);

    logic [COUNTER_WIDTH-1:0] cyc_left;

    // Load win_len-1 (a zero length behaves as one cycle); otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_left <= '0;
        end else if (load) begin
            cyc_left <= (win_len == '0) ? '0 : win_len - 1'b1;
        end else if (en && (cyc_left != '0)) begin
            cyc_left <= cyc_left - 1'b1;
        end
    end

    assign last_cycle = (cyc_left == '0);

endmodule

// File: rtl/axis_sniffer_window_ctrl.sv
// rtl/axis_sniffer_window_ctrl.sv - bandwidth measurement window sequencer for a tapped stream
module axis_sniffer_window_ctrl
    import sniffer_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int CLK_FREQ      = 200000000
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         stop,
    input  logic                                         continuous,
    input  logic                                         trigger_on_valid,
    input  logic [COUNTER_WIDTH-1:0]                     win_len,
    input  logic                                         tap_valid,
    input  logic                                         tap_ready,
    output logic                                         busy,
    output logic                                         result_valid,
    output logic [COUNTER_WIDTH-1:0]                     beat_count,
    output logic [COUNTER_WIDTH-1:0]                     stall_count,
    output logic [COUNTER_WIDTH+$clog2(DATA_WIDTH)-1:0]  bit_count,
    output logic [COUNTER_WIDTH-1:0]                     min_beats,
    output logic [COUNTER_WIDTH-1:0]                     max_beats,
    output logic [COUNTER_WIDTH-1:0]                     window_count
);

    localparam int SHIFT = $clog2(DATA_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] ALL_ONES = '1;

    if (((DATA_WIDTH & (DATA_WIDTH - 1)) != 0) || (CLK_FREQ <= 0)) begin : g_param_check
        $error("axis_sniffer_window_ctrl: DATA_WIDTH must be a power of 2 and CLK_FREQ positive");
    end

    state_t                   state, state_next;
    logic                     cont_r;
    logic                     stop_pending;
    logic [COUNTER_WIDTH-1:0] beat_acc, stall_acc;
    logic [COUNTER_WIDTH-1:0] new_beat, new_stall;
    logic                     accept_start, window_cycle, finish, timer_load, stop_set;
    logic                     last_cycle;

    sniffer_window_timer #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .en         (window_cycle),
        .win_len    (win_len),
        .last_cycle (last_cycle)
    );

    assign new_beat  = beat_acc  + COUNTER_WIDTH'(tap_valid & tap_ready);
    assign new_stall = stall_acc + COUNTER_WIDTH'(tap_valid & ~tap_ready);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        window_cycle = 1'b0;
        finish       = 1'b0;
        timer_load   = 1'b0;
        stop_set     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    accept_start = 1'b1;
                    timer_load   = 1'b1;
                    state_next   = trigger_on_valid ? ARMED : MEASURE;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (tap_valid) begin
                    window_cycle = 1'b1;
                    if (last_cycle) begin
                        finish = 1'b1;
                        if (cont_r) begin
                            timer_load = 1'b1;
                            state_next = MEASURE;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = MEASURE;
                    end
                end
            end
            MEASURE: begin
                window_cycle = 1'b1;
                if (last_cycle) begin
                    finish = 1'b1;
                    if (cont_r && !stop && !stop_pending) begin
                        timer_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    stop_set = stop;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulators, result latching and cross-window statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_r       <= 1'b0;
            stop_pending <= 1'b0;
            beat_acc     <= '0;
            stall_acc    <= '0;
            result_valid <= 1'b0;
            beat_count   <= '0;
            stall_count  <= '0;
            min_beats    <= ALL_ONES;
            max_beats    <= '0;
            window_count <= '0;
        end else begin
            result_valid <= finish;
            if (accept_start) begin
                cont_r       <= continuous;
                beat_acc     <= '0;
                stall_acc    <= '0;
                min_beats    <= ALL_ONES;
                max_beats    <= '0;
                window_count <= '0;
            end
            if (state_next == IDLE) begin
                stop_pending <= 1'b0;
            end else if (stop_set) begin
                stop_pending <= 1'b1;
            end
            if (window_cycle) begin
                if (finish) begin
                    beat_acc    <= '0;
                    stall_acc   <= '0;
                    beat_count  <= new_beat;
                    stall_count <= new_stall;
                    if (new_beat < min_beats) begin
                        min_beats <= new_beat;
                    end
                    if (new_beat > max_beats) begin
                        max_beats <= new_beat;
                    end
                    if (window_count != ALL_ONES) begin
                        window_count <= window_count + 1'b1;
                    end
                end else begin
                    beat_acc  <= new_beat;
                    stall_acc <= new_stall;
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign bit_count = (COUNTER_WIDTH + SHIFT)'(beat_count) << SHIFT;

endmodule

// File: tb/tb_axis_sniffer_window_ctrl.sv
// tb/tb_axis_sniffer_window_ctrl.sv - randomized self-checking bench for axis_sniffer_window_ctrl
module tb_axis_sniffer_window_ctrl;

    localparam int DW   = 256;
    localparam int CW   = 32;
    localparam int BW   = CW + 8;
    localparam int MAXN = 300;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, trigger_on_valid = 1'b0;
    logic [CW-1:0] win_len = '0;
    logic          tap_valid = 1'b0, tap_ready = 1'b0;
    logic          busy, result_valid;
    logic [CW-1:0] beat_count, stall_count, min_beats, max_beats, window_count;
    logic [BW-1:0] bit_count;

    int vectors = 0;
    int miscompares = 0;

    logic vv [MAXN];
    logic rr [MAXN];
    logic busy_log [MAXN];
    int   rel = 0;
    bit   rec_en = 1'b0;

    int            q_cyc[$];
    logic [CW-1:0] q_beat[$], q_stall[$], q_min[$], q_max[$], q_wc[$];
    logic [BW-1:0] q_bits[$];

    int            e_cyc[$];
    logic [CW-1:0] e_beat[$], e_stall[$], e_min[$], e_max[$], e_wc[$];
    logic [BW-1:0] e_bits[$];
    int            e_busy_end;

    axis_sniffer_window_ctrl #(
        .DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .CLK_FREQ(200000000)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
        .trigger_on_valid(trigger_on_valid), .win_len(win_len), .tap_valid(tap_valid),
        .tap_ready(tap_ready), .busy(busy), .result_valid(result_valid),
        .beat_count(beat_count), .stall_count(stall_count), .bit_count(bit_count),
        .min_beats(min_beats), .max_beats(max_beats), .window_count(window_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_en) begin
            busy_log[rel] = busy;
            if (result_valid) begin
                q_cyc.push_back(rel);
                q_beat.push_back(beat_count);
                q_stall.push_back(stall_count);
                q_bits.push_back(bit_count);
                q_min.push_back(min_beats);
                q_max.push_back(max_beats);
                q_wc.push_back(window_count);
            end
        end
    end

    // Reference: windows are contiguous spans of L cycles; sum beats/stalls in each span
    task automatic model(input int n, input bit cont, input bit trig, input logic [CW-1:0] wl, input int stop_at);
        int L, w, b, s;
        logic [CW-1:0] mn, mx, wc;
        e_cyc.delete(); e_beat.delete(); e_stall.delete(); e_bits.delete();
        e_min.delete(); e_max.delete(); e_wc.delete();
        e_busy_end = n;
        if (stop_at == 0) begin
            e_busy_end = 1;
            return;
        end
        L  = (wl == 0) ? 1 : int'(wl);
        mn = 32'hFFFF_FFFF; mx = 0; wc = 0;
        w  = 1;
        if (trig) begin
            w = -1;
            for (int i = 1; i < n; i++) if (vv[i]) begin w = i; break; end
            if (stop_at >= 1 && (w < 0 || stop_at <= w)) begin
                e_busy_end = stop_at + 1;
                return;
            end
            if (w < 0) return;
        end
        while (w + L < n) begin
            b = 0; s = 0;
            for (int c = w; c < w + L; c++) begin
                if (vv[c] && rr[c]) b++;
                else if (vv[c]) s++;
            end
            if (b < mn) mn = b;
            if (b > mx) mx = b;
            wc++;
            e_cyc.push_back(w + L);
            e_beat.push_back(b);
            e_stall.push_back(s);
            e_bits.push_back(BW'(b) * DW);
            e_min.push_back(mn);
            e_max.push_back(mx);
            e_wc.push_back(wc);
            if (!cont || (stop_at >= w && stop_at < w + L)) begin
                e_busy_end = w + L;
                break;
            end
            w += L;
        end
    endtask

    task automatic run(input string name, input int n, input bit cont, input bit trig,
                       input logic [CW-1:0] wl, input int stop_at, input int extra_start);
        int nb, ns;
        q_cyc.delete(); q_beat.delete(); q_stall.delete(); q_bits.delete();
        q_min.delete(); q_max.delete(); q_wc.delete();
        rec_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            start            = (i == 0) || (i == extra_start);
            stop             = (i == stop_at);
            continuous       = (i == 0) ? cont : !cont;
            trigger_on_valid = (i == 0) ? trig : !trig;
            win_len          = wl;
            tap_valid        = vv[i];
            tap_ready        = rr[i];
            rel              = i;
            @(posedge clk); #1;
        end
        rec_en = 1'b0;
        start = 0; stop = 0; tap_valid = 0; tap_ready = 0;
        model(n, cont, trig, wl, stop_at);

        vectors++;
        if (q_cyc.size() !== e_cyc.size()) begin
            miscompares++;
            $display("FAIL %s strobe_count: got %0d expected %0d", name, q_cyc.size(), e_cyc.size());
        end
        ns = (q_cyc.size() < e_cyc.size()) ? q_cyc.size() : e_cyc.size();
        for (int k = 0; k < ns; k++) begin
            vectors += 7;
            if (q_cyc[k] !== e_cyc[k]) begin miscompares++;
                $display("FAIL %s strobe_cycle[%0d]: got %0d expected %0d", name, k, q_cyc[k], e_cyc[k]); end
            if (q_beat[k] !== e_beat[k]) begin miscompares++;
                $display("FAIL %s beat_count[%0d]: got %0d expected %0d", name, k, q_beat[k], e_beat[k]); end
            if (q_stall[k] !== e_stall[k]) begin miscompares++;
                $display("FAIL %s stall_count[%0d]: got %0d expected %0d", name, k, q_stall[k], e_stall[k]); end
            if (q_bits[k] !== e_bits[k]) begin miscompares++;
                $display("FAIL %s bit_count[%0d]: got %0d expected %0d", name, k, q_bits[k], e_bits[k]); end
            if (q_min[k] !== e_min[k]) begin miscompares++;
                $display("FAIL %s min_beats[%0d]: got %0d expected %0d", name, k, q_min[k], e_min[k]); end
            if (q_max[k] !== e_max[k]) begin miscompares++;
                $display("FAIL %s max_beats[%0d]: got %0d expected %0d", name, k, q_max[k], e_max[k]); end
            if (q_wc[k] !== e_wc[k]) begin miscompares++;
                $display("FAIL %s window_count[%0d]: got %0d expected %0d", name, k, q_wc[k], e_wc[k]); end
        end
        nb = 0;
        for (int i = 0; i < n; i++)
            if (busy_log[i] !== ((i >= 1) && (i < e_busy_end))) nb++;
        vectors++;
        if (nb != 0) begin
            miscompares++;
            $display("FAIL %s busy_profile: got %0d wrong cycles expected 0 (busy until cycle %0d)", name, nb, e_busy_end);
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors += 8;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy: got %b expected 0", name, busy); end
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL %s result_valid: got %b expected 0", name, result_valid); end
        if (beat_count !== '0) begin miscompares++; $display("FAIL %s beat_count: got %0d expected 0", name, beat_count); end
        if (stall_count !== '0) begin miscompares++; $display("FAIL %s stall_count: got %0d expected 0", name, stall_count); end
        if (bit_count !== '0) begin miscompares++; $display("FAIL %s bit_count: got %0d expected 0", name, bit_count); end
        if (min_beats !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL %s min_beats: got %h expected ffffffff", name, min_beats); end
        if (max_beats !== '0) begin miscompares++; $display("FAIL %s max_beats: got %0d expected 0", name, max_beats); end
        if (window_count !== '0) begin miscompares++; $display("FAIL %s window_count: got %0d expected 0", name, window_count); end
    endtask

    task automatic fill(input int v_mode, input int r_mode);
        for (int i = 0; i < MAXN; i++) begin
            vv[i] = (v_mode == 1) ? 1'b1 : ((v_mode == 2) ? 1'($urandom_range(0, 9) < 7) : 1'b0);
            rr[i] = (r_mode == 1) ? 1'b1 : ((r_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_window();
        fill(1, 1);
        run("single_200", 260, 0, 0, 200, -1, -1);
    endtask

    task automatic test_ready_toggle();
        fill(1, 0);
        for (int i = 0; i < MAXN; i++) rr[i] = (i % 2 == 1);
        run("ready_toggle", 130, 0, 0, 100, -1, -1);
    endtask

    task automatic test_trigger();
        fill(1, 1);
        for (int i = 0; i < 30; i++) vv[i] = 1'b0;
        run("trigger", 60, 0, 1, 10, -1, -1);
    endtask

    task automatic test_back_to_back();
        fill(1, 1);
        for (int i = 51; i <= 100; i++) rr[i] = (i < 71);
        for (int i = 101; i <= 150; i++) rr[i] = (i < 136);
        for (int i = 151; i < MAXN; i++) vv[i] = 1'b0;
        run("continuous", 200, 1, 0, 50, 125, -1);
    endtask

    task automatic test_edge_cases();
        fill(1, 1);
        run("win_len_zero", 20, 1, 0, 0, 10, -1);
        run("start_stop_same", 20, 0, 0, 5, 0, -1);
        run("start_while_busy", 40, 0, 0, 20, -1, 7);
    endtask

    task automatic test_reset_mid_window();
        int seen;
        fill(1, 1);
        start = 1; continuous = 1; trigger_on_valid = 0; win_len = 50; tap_valid = 1; tap_ready = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("reset_mid");
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        @(posedge clk); #1;
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid activity_after_reset: got %0d active cycles expected 0", seen);
        end
        tap_valid = 0; tap_ready = 0;
        run("after_reset", 60, 0, 0, 30, -1, -1);
    endtask

    task automatic test_random();
        int k, stop_at;
        bit cont, trig;
        logic [CW-1:0] wl;
        for (int t = 0; t < 12; t++) begin
            fill(2, 2);
            cont = 1'($urandom_range(0, 1));
            trig = 1'($urandom_range(0, 1));
            wl   = CW'($urandom_range(0, 30));
            if (trig) begin
                k = $urandom_range(0, 20);
                for (int i = 1; i <= k; i++) vv[i] = 1'b0;
                vv[k + 1] = 1'b1;
            end
            if (cont || $urandom_range(0, 1) == 1) stop_at = $urandom_range(1, 150);
            else stop_at = -1;
            run($sformatf("random%0d", t), 250, cont, trig, wl, stop_at, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_ready_toggle();
        test_trigger();
        test_back_to_back();
        test_edge_cases();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
